pc_sequencer: RTL

Program-counter sequencer sitting at the receiving end of the branch/flag control FSM. It consumes that FSM's once-per-instruction latch strobe and branch-taken control and holds the architectural PC. It computes the next PC (sequential or PC-relative branch) and runs a request/acknowledge fetch handshake with instruction memory. It also reports a sticky overrun if the FSM strobes faster than fetches complete.

---
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: strobe-driven PC update with a req/ack fetch handshake.
// Optional PC_SEQ_INSTR_COUNT_EN adds a saturating instr_count_out.
module pc_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned OFF_W    = 6,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clka,
  input  logic             reset_in,
  input  logic             pc_latch_in,
  input  logic             pc_ctl_0_in,
  input  logic [OFF_W-1:0] offset_in,
  input  logic             fetch_ack_in,
  output logic [PC_W-1:0]  pc_out,
  output logic             fetch_req_out,
  output logic             branch_taken_out,
  output logic             overrun_out,
  output logic [1:0]       state_out
`ifdef PC_SEQ_INSTR_COUNT_EN
  ,
  output logic [15:0]      instr_count_out
`endif
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_FETCH  = 2'b01;
  localparam logic [1:0] S_WAIT   = 2'b10;
  localparam logic [1:0] S_UPDATE = 2'b11;

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             req_q, req_d;
  logic             bt_q, bt_d;
  logic             ov_q, ov_d;
  logic             latch_q;
  logic             pend_q, pend_d;
  logic             taken_q, taken_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             rise;
  logic             capture;
  logic [PC_W-1:0]  off_ext;

`ifdef PC_SEQ_INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  assign off_ext = PC_W'($signed(off_q));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    bt_d    = bt_q;
    ov_d    = ov_q;
    pend_d  = pend_q;
    taken_d = taken_q;
    off_d   = off_q;
    capture = 1'b0;
    rise    = pc_latch_in & ~latch_q;

    case (state_q)
      S_IDLE, S_FETCH: begin
        // Only one strobe can be held; a second one before service is lost.
        if (rise) begin
          if (pend_q) begin
            ov_d = 1'b1;
          end else begin
            pend_d  = 1'b1;
            capture = 1'b1;
          end
        end
        if (state_q == S_IDLE) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
        end else if (fetch_ack_in) begin
          req_d   = 1'b0;
          state_d = (pend_q || rise) ? S_UPDATE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (rise) begin
          capture = 1'b1;
          state_d = S_UPDATE;
        end
      end
      default: begin
        pc_d    = pc_q + PC_W'(1) + (taken_q ? off_ext : PC_W'(0));
        bt_d    = taken_q;
        req_d   = 1'b1;
        state_d = S_FETCH;
        // The strobe being serviced is consumed here; a new one becomes pending.
        pend_d  = rise;
        capture = rise;
      end
    endcase

    if (capture) begin
      taken_d = pc_ctl_0_in;
      off_d   = offset_in;
    end
  end

`ifdef PC_SEQ_INSTR_COUNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_UPDATE && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end
`endif

  always_ff @(negedge clka or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RST;
      req_q   <= 1'b0;
      bt_q    <= 1'b0;
      ov_q    <= 1'b0;
      latch_q <= 1'b0;
      pend_q  <= 1'b0;
      taken_q <= 1'b0;
      off_q   <= '0;
`ifdef PC_SEQ_INSTR_COUNT_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      bt_q    <= bt_d;
      ov_q    <= ov_d;
      latch_q <= pc_latch_in;
      pend_q  <= pend_d;
      taken_q <= taken_d;
      off_q   <= off_d;
`ifdef PC_SEQ_INSTR_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign pc_out           = pc_q;
  assign fetch_req_out    = req_q;
  assign branch_taken_out = bt_q;
  assign overrun_out      = ov_q;
  assign state_out        = state_q;
`ifdef PC_SEQ_INSTR_COUNT_EN
  assign instr_count_out  = cnt_q;
`endif

endmodule
